boton_acondicionador: RTL
=========================

Name: boton_acondicionador

Overview:
Conditions the five raw push buttons (izquierda, derecha, arriba, abajo, centro) before they reach the write state machine and the stopwatch logic. Per button it performs:
- 2-flop synchronisation
- counter-based debounce
- single-cycle press pulse generation
- optional auto-repeat, so held arriba/abajo keep stepping the field being edited

It sits directly upstream of MaquinaEscritura and the stopwatch control, replacing the raw pad signals with clean pulses.

Parameters:
N_BOTONES, 5, number of independent button channels; bit order is izquierda, derecha, arriba, abajo, centro (bit 0 = izquierda).
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a level change (10 ms at 100 MHz); minimum 2.
REPEAT_DELAY, 50000000, cycles from the press pulse to the first repeat pulse; minimum 2.
REPEAT_RATE, 10000000, cycles between subsequent repeat pulses; minimum 2.
REPEAT_MASK, 5'b01100, per-button auto-repeat enable (default: arriba and abajo only).
CNT_W, 26, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE).

Ports:
clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
push_raw  input  N_BOTONES  asynchronous raw button pads, active high
enable  input  1  when low, push_pulse is suppressed and all repeat FSMs are held in IDLE
push_level  output  N_BOTONES  debounced button level
push_pulse  output  N_BOTONES  one-cycle pulse on an accepted press and on each repeat
push_any  output  1  OR of push_pulse, registered together with it

Behaviour:
Reset (synchronous, while Reset=1 at the clock edge):
- Cleared: sync flops, debounce counters, repeat counters, push_level, push_pulse, push_any.
- All FSMs go to IDLE.
- Reset overrides every other event in the same cycle.

Synchroniser:
- sync1 <= push_raw; sync2 <= sync1.
- Only sync2 is used downstream.

Debounce (per channel):
- If sync2 == push_level, the counter is cleared to 0.
- Otherwise the counter increments.
- When the counter equals DEBOUNCE_CYCLES-1 and sync2 still differs from push_level: push_level <= sync2 and the counter is cleared.
- Any glitch shorter than DEBOUNCE_CYCLES restarts the count, so push_level never changes.
- Latency: a clean rising edge on push_raw sampled at edge k gives push_level=1 after edge k+1+DEBOUNCE_CYCLES. A falling edge has the same latency.

Press/repeat FSM (per channel), states IDLE, HOLD_DELAY, HOLD_REPEAT:
- IDLE: on the push_level 0->1 update cycle, with enable=1:
  - push_pulse[i]=1 in the same cycle push_level rises (both registered on the same edge).
  - Then go to HOLD_DELAY if REPEAT_MASK[i]=1, else stay parked in IDLE until release.
  - Releases produce no pulse.
- HOLD_DELAY: count cycles since the press pulse. At REPEAT_DELAY: pulse and go to HOLD_REPEAT.
- HOLD_REPEAT: pulse every REPEAT_RATE cycles.
- Exit from either hold state: push_level=0 or enable=0 returns the FSM to IDLE immediately, clears the repeat counter, and produces no pulse in that cycle.
- A press that completes debounce while enable=0 produces no pulse. Raising enable later while the button is still held does not produce a pulse; the button must be released and pressed again.

Outputs:
- push_pulse is at most one cycle wide per event.
- Channels are fully independent. Simultaneous presses pulse in the same cycle; no priority and no lockout.
- push_any is the registered OR of the push_pulse next-state values, coincident with push_pulse.

Reset mid-operation:
- After Reset deasserts with a button still held, the press is treated as a new one: push_level rises and one pulse fires after the full synchronisation plus debounce latency.

Counters:
- All counters are CNT_W bits and unsigned.
- They never wrap, because each is cleared at its terminal count.

Test Plan:
(All with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_MASK=5'b01100, enable=1 unless stated.)
1. Clean press: push_raw[4] 0->1 sampled at edge 0, held 40 cycles -> push_level[4]=1 and push_pulse[4]=1 after edge 5. That is the only pulse, because centro does not repeat. No pulse on release; push_level[4]=0 five edges after release.
2. Bounce rejection: push_raw[0] toggles 1,0,1,0,1 with 3-cycle high/low phases, then stays high -> no pulse during the bounce; exactly one pulse five edges after the last 0->1 transition.
3. Auto-repeat: push_raw[2] held 30 cycles -> pulses at the press cycle P, then P+10, P+13, P+16, ... until push_level falls; push_any mirrors each pulse.
4. Simultaneous presses: push_raw[2] and push_raw[3] rise on the same edge -> push_pulse=5'b01100 in one cycle; push_any=1 for one cycle.
5. enable gating: press button 2 with enable=0 until after debounce, then raise enable while still held -> no pulses at all. Release, then press again with enable=1 -> normal pulse train.
6. Reset mid-hold: assert Reset for 1 cycle during HOLD_REPEAT on button 3 with raw still high -> all outputs 0 on the next edge; a fresh pulse appears 6 edges after Reset deasserts, and repeats resume on the REPEAT_DELAY/REPEAT_RATE schedule.

Source files
------------

// File: rtl/boton_acondicionador.sv
// Five-channel push-button conditioner: 2-flop synchroniser, counter debounce,
// single-cycle press pulse and optional auto-repeat while a button is held.
module boton_acondicionador #(
  parameter int                   N_BOTONES       = 5,
  parameter int                   DEBOUNCE_CYCLES = 1000000,
  parameter int                   REPEAT_DELAY    = 50000000,
  parameter int                   REPEAT_RATE     = 10000000,
  parameter logic [N_BOTONES-1:0] REPEAT_MASK     = 5'b01100,
  parameter int                   CNT_W           = 26
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [N_BOTONES-1:0] push_raw,
  input  logic                 enable,
  output logic [N_BOTONES-1:0] push_level,
  output logic [N_BOTONES-1:0] push_pulse,
  output logic                 push_any
);

  typedef enum logic [1:0] {IDLE, HOLD_DELAY, HOLD_REPEAT} estado_t;

  localparam logic [CNT_W-1:0] UNO     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

  logic [N_BOTONES-1:0] sync1_q, sync2_q;
  logic [N_BOTONES-1:0] level_q, level_d;
  logic [N_BOTONES-1:0] pulse_q, pulse_d;
  logic                 any_q;
  logic [CNT_W-1:0]     deb_q [N_BOTONES];
  logic [CNT_W-1:0]     deb_d [N_BOTONES];
  logic [CNT_W-1:0]     rep_q [N_BOTONES];
  logic [CNT_W-1:0]     rep_d [N_BOTONES];
  estado_t              estado_q [N_BOTONES];
  estado_t              estado_d [N_BOTONES];

  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < N_BOTONES; i++) begin
      deb_d[i]    = deb_q[i];
      rep_d[i]    = rep_q[i];
      estado_d[i] = estado_q[i];

      if (sync2_q[i] == level_q[i]) begin
        deb_d[i] = '0;
      end else if (deb_q[i] == DB_LAST) begin
        level_d[i] = sync2_q[i];
        deb_d[i]   = '0;
      end else begin
        deb_d[i] = deb_q[i] + UNO;
      end

      // The FSM looks at level_d so the press pulse lands on the same edge as
      // the level rise, and a release suppresses any repeat due that edge.
      case (estado_q[i])
        IDLE: begin
          rep_d[i] = '0;
          if (enable && level_d[i] && !level_q[i]) begin
            pulse_d[i] = 1'b1;
            if (REPEAT_MASK[i]) estado_d[i] = HOLD_DELAY;
          end
        end
        HOLD_DELAY: begin
          if (!enable || !level_d[i]) begin
            estado_d[i] = IDLE;
            rep_d[i]    = '0;
          end else if (rep_q[i] == RD_LAST) begin
            pulse_d[i]  = 1'b1;
            rep_d[i]    = '0;
            estado_d[i] = HOLD_REPEAT;
          end else begin
            rep_d[i] = rep_q[i] + UNO;
          end
        end
        HOLD_REPEAT: begin
          if (!enable || !level_d[i]) begin
            estado_d[i] = IDLE;
            rep_d[i]    = '0;
          end else if (rep_q[i] == RR_LAST) begin
            pulse_d[i] = 1'b1;
            rep_d[i]   = '0;
          end else begin
            rep_d[i] = rep_q[i] + UNO;
          end
        end
        default: begin
          estado_d[i] = IDLE;
          rep_d[i]    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < N_BOTONES; i++) begin
        deb_q[i]    <= '0;
        rep_q[i]    <= '0;
        estado_q[i] <= IDLE;
      end
    end else begin
      sync1_q  <= push_raw;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      any_q    <= |pulse_d;
      deb_q    <= deb_d;
      rep_q    <= rep_d;
      estado_q <= estado_d;
    end
  end

  assign push_level = level_q;
  assign push_pulse = pulse_q;
  assign push_any   = any_q;

endmodule
